// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch control core.
//   state_e      - control FSM state (IDLE, RUN, PAUSE, LAP), 2 bits
//   bcd_t        - one 4-bit BCD digit
//   CS_MAX/SEC_MAX - centisecond and second wrap points
//   *_LSB        - bit offsets of each digit inside the 24-bit display word
//   bin2bcd2()   - turns a 0..99 constant into its two-digit BCD form
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;
  localparam int DISP_W  = 24;

  // disp_bcd = {min10, min1, sec10, sec1, cs10, cs1}
  localparam int MIN10_LSB = 20;
  localparam int MIN1_LSB  = 16;
  localparam int SEC10_LSB = 12;
  localparam int SEC1_LSB  = 8;
  localparam int CS10_LSB  = 4;
  localparam int CS1_LSB   = 0;

  function automatic logic [7:0] bin2bcd2(input int v);
    bin2bcd2 = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: bundles the stopwatch core's functional signals.
//   tick_100Hz  - 10 ms single-cycle pulse from the divider (into core)
//   btn_ss      - start/stop button level, debounced (into core)
//   btn_lr      - lap/reset button level, debounced (into core)
//   div_reset_n - active-low synchronous reset back to the divider
//   disp_bcd    - 6-digit BCD display word
//   running     - high in RUN or LAP
//   lap_active  - high in LAP
//   overflow    - one-cycle pulse on rollover/saturation
// slave modport is the core's view, master the driver/observer's view.
interface stopwatch_ctrl_if;
  logic        tick_100Hz;
  logic        btn_ss;
  logic        btn_lr;
  logic        div_reset_n;
  logic [23:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport slave (
    input  tick_100Hz, btn_ss, btn_lr,
    output div_reset_n, disp_bcd, running, lap_active, overflow
  );

  modport master (
    output tick_100Hz, btn_ss, btn_lr,
    input  div_reset_n, disp_bcd, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping 0..MOD_MAX.
//   CLK_50_MHz - clock
//   reset_n    - synchronous active-low reset
//   clr_i      - synchronous clear (wins over inc_i)
//   inc_i      - advance by one
//   hi_o/lo_o  - tens / units digit
//   at_max_o   - value currently equals MOD_MAX
//   carry_o    - inc_i while at MOD_MAX (next digit pair should advance)
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MOD_MAX = 99
) (
  input  logic CLK_50_MHz,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output bcd_t hi_o,
  output bcd_t lo_o,
  output logic at_max_o,
  output logic carry_o
);

  localparam logic [7:0] MAX_BCD = bin2bcd2(MOD_MAX);

  bcd_t hi_q, hi_d, lo_q, lo_d;
  logic at_max;

  assign at_max = ({hi_q, lo_q} == MAX_BCD);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (clr_i) begin
      hi_d = '0;
      lo_d = '0;
    end else if (inc_i) begin
      if (at_max) begin
        hi_d = '0;
        lo_d = '0;
      end else if (lo_q == 4'd9) begin
        hi_d = hi_q + 4'd1;
        lo_d = '0;
      end else begin
        lo_d = lo_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK_50_MHz) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign at_max_o = at_max;
  assign carry_o  = inc_i & at_max;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM and MM:SS.cc time-keeping core.
//   CLK_50_MHz - system clock
//   reset_n    - synchronous active-low reset
//   bus        - stopwatch_ctrl_if.slave (tick, buttons, divider reset,
//                display word, status flags, overflow pulse)
// Parameters: MAX_MIN (top minute value, <= 99), DIV_RST_CYCLES (>= 1,
// length of the divider reset pulse issued on a start from IDLE).
// Build option STOPWATCH_SAT_EN: saturate at MAX_MIN:59.99 and drop to
// PAUSE instead of wrapping to 00:00.00.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN        = 59,
  parameter int DIV_RST_CYCLES = 2
) (
  input  logic             CLK_50_MHz,
  input  logic             reset_n,
  stopwatch_ctrl_if.slave  bus
);

  localparam int DCW = (DIV_RST_CYCLES > 1) ? $clog2(DIV_RST_CYCLES) : 1;

  state_e          state_q;
  logic            btn_ss_q, btn_lr_q;
  logic            div_rst_n_q;
  logic [DCW-1:0]  div_cnt_q;
  logic            running_q, lap_active_q, overflow_q;
  logic [DISP_W-1:0] lap_reg_q, disp_q;

  logic ss_edge, lr_edge, cnt_tick, clr_cnt, all_max, ovf_evt, cs_inc;
  bcd_t cs_hi, cs_lo, sec_hi, sec_lo, min_hi, min_lo;
  logic cs_max, sec_max, min_max, cs_carry, sec_carry, min_carry;
  logic [DISP_W-1:0] count_w;

  // Start/stop has priority: a simultaneous lap/reset edge is discarded.
  assign ss_edge = bus.btn_ss & ~btn_ss_q;
  assign lr_edge = bus.btn_lr & ~btn_lr_q & ~ss_edge;

  // Uses the pre-transition state, so a tick landing with a stop edge counts.
  assign cnt_tick = bus.tick_100Hz & div_rst_n_q &
                    ((state_q == RUN) | (state_q == LAP));
  assign clr_cnt  = (state_q == PAUSE) & lr_edge;
  assign all_max  = cs_max & sec_max & min_max;

`ifdef STOPWATCH_SAT_EN
  assign cs_inc = cnt_tick & ~all_max;
`else
  assign cs_inc = cnt_tick;
`endif
  // Wrapping: min_carry fires on the rollover tick. Saturating: min_carry
  // can never fire, the held-at-max tick is what counts.
  assign ovf_evt = min_carry | (cnt_tick & all_max);

  bcd_mod_counter #(.MOD_MAX(CS_MAX)) u_cs (
    .CLK_50_MHz(CLK_50_MHz), .reset_n(reset_n), .clr_i(clr_cnt),
    .inc_i(cs_inc), .hi_o(cs_hi), .lo_o(cs_lo),
    .at_max_o(cs_max), .carry_o(cs_carry)
  );

  bcd_mod_counter #(.MOD_MAX(SEC_MAX)) u_sec (
    .CLK_50_MHz(CLK_50_MHz), .reset_n(reset_n), .clr_i(clr_cnt),
    .inc_i(cs_carry), .hi_o(sec_hi), .lo_o(sec_lo),
    .at_max_o(sec_max), .carry_o(sec_carry)
  );

  bcd_mod_counter #(.MOD_MAX(MAX_MIN)) u_min (
    .CLK_50_MHz(CLK_50_MHz), .reset_n(reset_n), .clr_i(clr_cnt),
    .inc_i(sec_carry), .hi_o(min_hi), .lo_o(min_lo),
    .at_max_o(min_max), .carry_o(min_carry)
  );

  assign count_w = {min_hi, min_lo, sec_hi, sec_lo, cs_hi, cs_lo};

  always_ff @(posedge CLK_50_MHz) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      btn_ss_q     <= 1'b1;  // a button held through reset yields no edge
      btn_lr_q     <= 1'b1;
      div_rst_n_q  <= 1'b1;
      div_cnt_q    <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      lap_reg_q    <= '0;
      disp_q       <= '0;
    end else begin
      btn_ss_q   <= bus.btn_ss;
      btn_lr_q   <= bus.btn_lr;
      overflow_q <= ovf_evt;
      disp_q     <= (state_q == LAP) ? lap_reg_q : count_w;

      if (!div_rst_n_q) begin
        if (div_cnt_q == '0) div_rst_n_q <= 1'b1;
        else                 div_cnt_q   <= div_cnt_q - 1'b1;
      end

      unique case (state_q)
        IDLE: if (ss_edge) begin
          state_q     <= RUN;
          running_q   <= 1'b1;
          div_rst_n_q <= 1'b0;
          div_cnt_q   <= DCW'(DIV_RST_CYCLES - 1);
        end
        RUN: if (ss_edge) begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
        end else if (lr_edge) begin
          state_q      <= LAP;
          lap_active_q <= 1'b1;
          lap_reg_q    <= count_w;
        end
        LAP: if (ss_edge) begin
          state_q      <= PAUSE;
          running_q    <= 1'b0;
          lap_active_q <= 1'b0;
        end else if (lr_edge) begin
          state_q      <= RUN;
          lap_active_q <= 1'b0;
        end
        PAUSE: if (ss_edge) begin
          state_q   <= RUN;  // divider phase kept
          running_q <= 1'b1;
        end else if (lr_edge) begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

`ifdef STOPWATCH_SAT_EN
      if (ovf_evt) begin
        state_q      <= PAUSE;
        running_q    <= 1'b0;
        lap_active_q <= 1'b0;
      end
`endif
    end
  end

  assign bus.div_reset_n = div_rst_n_q;
  assign bus.disp_bcd    = disp_q;
  assign bus.running     = running_q;
  assign bus.lap_active  = lap_active_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed, table-driven bench for stopwatch_ctrl.
// MAX_MIN is set to 1 so the rollover point (01:59.99) is reachable.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.MAX_MIN(1), .DIV_RST_CYCLES(2)) dut (
    .CLK_50_MHz(clk),
    .reset_n   (rst_n),
    .bus       (sw_if)
  );

  typedef struct {
    logic        ss;
    logic        lr;
    int          ticks;
    logic [23:0] disp;
    logic        run;
    logic        lap;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance n clocks; returns at a falling edge (inputs driven / outputs sampled here).
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Press buttons one cycle, let the divider reset finish, apply back-to-back
  // ticks, settle, then compare display and status.
  task automatic apply(input vec_t v, input int idx);
    sw_if.btn_ss = v.ss;
    sw_if.btn_lr = v.lr;
    step(1);
    sw_if.btn_ss = 1'b0;
    sw_if.btn_lr = 1'b0;
    step(4);
    if (v.ticks > 0) begin
      sw_if.tick_100Hz = 1'b1;
      step(v.ticks);
      sw_if.tick_100Hz = 1'b0;
    end
    step(3);
    chk($sformatf("vec%0d disp", idx), 32'(sw_if.disp_bcd), 32'(v.disp));
    chk($sformatf("vec%0d running", idx), 32'(sw_if.running), 32'(v.run));
    chk($sformatf("vec%0d lap_active", idx), 32'(sw_if.lap_active), 32'(v.lap));
  endtask

  vec_t tbl_a[9];
  vec_t tbl_b[3];

  initial begin
    tbl_a[0] = '{1'b0, 1'b0, 100, 24'h000100, 1'b1, 1'b0}; // count to 1.00 s
    tbl_a[1] = '{1'b0, 1'b1,  50, 24'h000100, 1'b1, 1'b1}; // lap freezes display
    tbl_a[2] = '{1'b0, 1'b1,   0, 24'h000150, 1'b1, 1'b0}; // back to live
    tbl_a[3] = '{1'b1, 1'b0,  20, 24'h000150, 1'b0, 1'b0}; // pause ignores ticks
    tbl_a[4] = '{1'b1, 1'b0,   0, 24'h000150, 1'b1, 1'b0}; // resume
    tbl_a[5] = '{1'b1, 1'b0,   0, 24'h000150, 1'b0, 1'b0}; // pause again
    tbl_a[6] = '{1'b0, 1'b1,   0, 24'h000000, 1'b0, 1'b0}; // clear -> IDLE
    tbl_a[7] = '{1'b0, 1'b1,   5, 24'h000000, 1'b0, 1'b0}; // lr in IDLE ignored
    tbl_a[8] = '{1'b1, 1'b0, 150, 24'h000150, 1'b1, 1'b0}; // start, 150 ticks
    tbl_b[0] = '{1'b0, 1'b1,    0, 24'h000000, 1'b0, 1'b0}; // PAUSE -> IDLE
    tbl_b[1] = '{1'b1, 1'b0, 6000, 24'h010000, 1'b1, 1'b0}; // minute carry
    tbl_b[2] = '{1'b0, 1'b0, 5999, 24'h015999, 1'b1, 1'b0}; // up to 01:59.99

    sw_if.tick_100Hz = 1'b0;
    sw_if.btn_ss     = 1'b0;
    sw_if.btn_lr     = 1'b0;
    @(negedge clk);
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("rst disp", 32'(sw_if.disp_bcd), 32'h0);
    chk("rst running", 32'(sw_if.running), 32'h0);
    chk("rst lap_active", 32'(sw_if.lap_active), 32'h0);
    chk("rst overflow", 32'(sw_if.overflow), 32'h0);
    chk("rst div_reset_n", 32'(sw_if.div_reset_n), 32'h1);

    // Start from IDLE: div_reset_n low exactly two cycles; ticks held high
    // meanwhile must not count.
    sw_if.btn_ss = 1'b1;
    sw_if.tick_100Hz = 1'b1;
    step(1);
    chk("start div low c1", 32'(sw_if.div_reset_n), 32'h0);
    sw_if.btn_ss = 1'b0;
    step(1);
    chk("start div low c2", 32'(sw_if.div_reset_n), 32'h0);
    step(1);
    chk("start div released", 32'(sw_if.div_reset_n), 32'h1);
    sw_if.tick_100Hz = 1'b0;
    step(3);
    chk("start no count during div rst", 32'(sw_if.disp_bcd), 32'h0);
    chk("start running", 32'(sw_if.running), 32'h1);

    for (int i = 0; i < 9; i++) apply(tbl_a[i], i);

    // Simultaneous ss+lr with a tick in RUN: PAUSE, no lap, tick counted.
    sw_if.btn_ss = 1'b1;
    sw_if.btn_lr = 1'b1;
    sw_if.tick_100Hz = 1'b1;
    step(1);
    sw_if.btn_ss = 1'b0;
    sw_if.btn_lr = 1'b0;
    sw_if.tick_100Hz = 1'b0;
    step(3);
    chk("simul disp", 32'(sw_if.disp_bcd), 32'h000151);
    chk("simul running", 32'(sw_if.running), 32'h0);
    chk("simul lap_active", 32'(sw_if.lap_active), 32'h0);

    for (int i = 0; i < 3; i++) apply(tbl_b[i], 9 + i);

    // Rollover / saturation at 01:59.99.
    sw_if.tick_100Hz = 1'b1;
    step(1);
    sw_if.tick_100Hz = 1'b0;
    chk("ovf pulse", 32'(sw_if.overflow), 32'h1);
    step(1);
    chk("ovf one cycle", 32'(sw_if.overflow), 32'h0);
`ifdef STOPWATCH_SAT_EN
    chk("sat disp", 32'(sw_if.disp_bcd), 32'h015999);
    chk("sat running", 32'(sw_if.running), 32'h0);
`else
    chk("wrap disp", 32'(sw_if.disp_bcd), 32'h000000);
    chk("wrap running", 32'(sw_if.running), 32'h1);
`endif

    // btn_ss held through reset release must not start the watch.
    rst_n = 1'b0;
    sw_if.btn_ss = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("held btn running", 32'(sw_if.running), 32'h0);
    chk("held btn div", 32'(sw_if.div_reset_n), 32'h1);
    chk("held btn disp", 32'(sw_if.disp_bcd), 32'h0);

    // Reset in the middle of a divider reset pulse.
    sw_if.btn_ss = 1'b0;
    step(1);
    sw_if.btn_ss = 1'b1;
    step(1);
    chk("mid pulse div low", 32'(sw_if.div_reset_n), 32'h0);
    rst_n = 1'b0;
    step(1);
    chk("mid rst div", 32'(sw_if.div_reset_n), 32'h1);
    chk("mid rst running", 32'(sw_if.running), 32'h0);
    chk("mid rst disp", 32'(sw_if.disp_bcd), 32'h0);
    chk("mid rst overflow", 32'(sw_if.overflow), 32'h0);
    rst_n = 1'b1;
    sw_if.btn_ss = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
